// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one L2 port between the L1 I-cache and D-cache miss paths.
// Request/data outputs are a combinational mux on the registered grant state.
module cache_arbiter #(
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [15:0]           icache_pmem_address,
    input  logic                  icache_pmem_read,
    output logic [LINE_WIDTH-1:0] icache_pmem_rdata,
    output logic                  icache_pmem_resp,

    input  logic [15:0]           dcache_pmem_address,
    input  logic [LINE_WIDTH-1:0] dcache_pmem_wdata,
    input  logic                  dcache_pmem_read,
    input  logic                  dcache_pmem_write,
    output logic [LINE_WIDTH-1:0] dcache_pmem_rdata,
    output logic                  dcache_pmem_resp,

    output logic [15:0]           l2_address,
    output logic [LINE_WIDTH-1:0] l2_wdata,
    output logic                  l2_read,
    output logic                  l2_write,
    input  logic [LINE_WIDTH-1:0] l2_rdata,
    input  logic                  l2_resp
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT_I,
        GRANT_D
    } state_t;

    state_t r_state;
    logic   r_last_d;

    logic   w_i_req;
    logic   w_d_req;

    assign w_i_req = icache_pmem_read;
    assign w_d_req = dcache_pmem_read | dcache_pmem_write;

    // A grant also ends early if its requester drops the request without a response.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_last_d <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_i_req && (!w_d_req || r_last_d)) begin
                        r_state  <= GRANT_I;
                        r_last_d <= 1'b0;
                    end else if (w_d_req) begin
                        r_state  <= GRANT_D;
                        r_last_d <= 1'b1;
                    end
                end
                GRANT_I: begin
                    if (l2_resp || !w_i_req)
                        r_state <= IDLE;
                end
                GRANT_D: begin
                    if (l2_resp || !w_d_req)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Outputs are forced quiet while reset is held so an abandoned grant never leaks.
    always_comb begin
        icache_pmem_rdata = l2_rdata;
        dcache_pmem_rdata = l2_rdata;
        icache_pmem_resp  = 1'b0;
        dcache_pmem_resp  = 1'b0;
        l2_address        = '0;
        l2_wdata          = '0;
        l2_read           = 1'b0;
        l2_write          = 1'b0;
        if (!reset) begin
            case (r_state)
                GRANT_I: begin
                    l2_address       = icache_pmem_address;
                    l2_read          = icache_pmem_read;
                    icache_pmem_resp = l2_resp;
                end
                GRANT_D: begin
                    l2_address       = dcache_pmem_address;
                    l2_wdata         = dcache_pmem_wdata;
                    l2_read          = dcache_pmem_read;
                    l2_write         = dcache_pmem_write;
                    dcache_pmem_resp = l2_resp;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: an ownership/history model checked every cycle,
// plus literal expectations for the scenarios of interest.
module tb_cache_arbiter;

    localparam int LW = 128;

    logic          clk = 1'b0;
    logic          reset;
    logic [15:0]   icache_pmem_address;
    logic          icache_pmem_read;
    logic [LW-1:0] icache_pmem_rdata;
    logic          icache_pmem_resp;
    logic [15:0]   dcache_pmem_address;
    logic [LW-1:0] dcache_pmem_wdata;
    logic          dcache_pmem_read;
    logic          dcache_pmem_write;
    logic [LW-1:0] dcache_pmem_rdata;
    logic          dcache_pmem_resp;
    logic [15:0]   l2_address;
    logic [LW-1:0] l2_wdata;
    logic          l2_read;
    logic          l2_write;
    logic [LW-1:0] l2_rdata;
    logic          l2_resp;

    int n_checks = 0;
    int n_errors = 0;

    cache_arbiter #(.LINE_WIDTH(LW)) dut (
        .clk                 (clk),
        .reset               (reset),
        .icache_pmem_address (icache_pmem_address),
        .icache_pmem_read    (icache_pmem_read),
        .icache_pmem_rdata   (icache_pmem_rdata),
        .icache_pmem_resp    (icache_pmem_resp),
        .dcache_pmem_address (dcache_pmem_address),
        .dcache_pmem_wdata   (dcache_pmem_wdata),
        .dcache_pmem_read    (dcache_pmem_read),
        .dcache_pmem_write   (dcache_pmem_write),
        .dcache_pmem_rdata   (dcache_pmem_rdata),
        .dcache_pmem_resp    (dcache_pmem_resp),
        .l2_address          (l2_address),
        .l2_wdata            (l2_wdata),
        .l2_read             (l2_read),
        .l2_write            (l2_write),
        .l2_rdata            (l2_rdata),
        .l2_resp             (l2_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: owner -1 = nobody, 0 = I-cache, 1 = D-cache; history lists every grant since reset.
    int m_owner = -1;
    int m_hist[$];

    always @(posedge clk) begin
        int nxt;
        logic wi, wd;
        nxt = m_owner;
        wi  = icache_pmem_read;
        wd  = dcache_pmem_read | dcache_pmem_write;
        if (reset) begin
            nxt = -1;
            m_hist.delete();
        end else if (m_owner == 0) begin
            if (l2_resp || !wi) nxt = -1;
        end else if (m_owner == 1) begin
            if (l2_resp || !wd) nxt = -1;
        end else begin
            if (wi && wd)
                nxt = (m_hist.size() > 0 && m_hist[$] == 0) ? 1 : 0;
            else if (wi)
                nxt = 0;
            else if (wd)
                nxt = 1;
            if (nxt >= 0) m_hist.push_back(nxt);
        end
        m_owner <= nxt;
    end

    always @(negedge clk) begin
        logic [15:0]   ea;
        logic [LW-1:0] ew;
        logic          er, ewr, eir, edr;
        ea = '0; ew = '0; er = 1'b0; ewr = 1'b0; eir = 1'b0; edr = 1'b0;
        if (!reset && m_owner == 0) begin
            ea  = icache_pmem_address;
            er  = icache_pmem_read;
            eir = l2_resp;
        end else if (!reset && m_owner == 1) begin
            ea  = dcache_pmem_address;
            ew  = dcache_pmem_wdata;
            er  = dcache_pmem_read;
            ewr = dcache_pmem_write;
            edr = l2_resp;
        end
        chk("m_l2_address", LW'(l2_address), LW'(ea));
        chk("m_l2_wdata", l2_wdata, ew);
        chk("m_l2_read", LW'(l2_read), LW'(er));
        chk("m_l2_write", LW'(l2_write), LW'(ewr));
        chk("m_i_resp", LW'(icache_pmem_resp), LW'(eir));
        chk("m_d_resp", LW'(dcache_pmem_resp), LW'(edr));
        chk("m_i_rdata", icache_pmem_rdata, l2_rdata);
        chk("m_d_rdata", dcache_pmem_rdata, l2_rdata);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Acts as L2: waits (bounded) for a strobe, responds after lat more cycles,
    // reports which requester saw the response.
    task automatic serve(input int lat, input logic [LW-1:0] data, output int who);
        int n;
        n   = 0;
        who = -1;
        while (!(l2_read || l2_write) && n < 20) begin
            cyc(1);
            n++;
        end
        if (n >= 20) begin
            n_checks++;
            n_errors++;
            $display("FAIL grant_timeout got no strobe expected strobe within 20 cycles");
            return;
        end
        cyc(lat);
        l2_rdata = data;
        l2_resp  = 1'b1;
        #1;
        if (icache_pmem_resp && !dcache_pmem_resp) who = 0;
        else if (dcache_pmem_resp && !icache_pmem_resp) who = 1;
        cyc(1);
        l2_resp = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int who;
        int order[$];
        int exp_order[6] = '{0, 1, 0, 1, 0, 1};
        logic [LW-1:0] wd_pat;
        wd_pat = 128'h0123456789ABCDEF0123456789ABCDEF;

        reset = 1'b1;
        icache_pmem_address = '0; icache_pmem_read = 1'b0;
        dcache_pmem_address = '0; dcache_pmem_wdata = '0;
        dcache_pmem_read = 1'b0; dcache_pmem_write = 1'b0;
        l2_rdata = '0; l2_resp = 1'b0;
        cyc(2);
        chk("rst_l2_read", LW'(l2_read), '0);
        chk("rst_l2_address", LW'(l2_address), '0);

        // I-cache read alone.
        reset = 1'b0;
        icache_pmem_read = 1'b1;
        icache_pmem_address = 16'h1230;
        cyc(1);
        chk("t1_l2_read", LW'(l2_read), LW'(1));
        chk("t1_l2_address", LW'(l2_address), LW'(16'h1230));
        serve(2, {32{4'hA}}, who);
        chk("t1_who", LW'(who), LW'(0));
        icache_pmem_read = 1'b0;
        #1;
        chk("t1_bubble", LW'(l2_read), '0);
        cyc(1);

        // D-cache writeback alone.
        dcache_pmem_address = 16'h4560;
        dcache_pmem_wdata = wd_pat;
        dcache_pmem_write = 1'b1;
        cyc(1);
        chk("t2_l2_write", LW'(l2_write), LW'(1));
        chk("t2_l2_read", LW'(l2_read), '0);
        chk("t2_l2_wdata", l2_wdata, wd_pat);
        chk("t2_l2_address", LW'(l2_address), LW'(16'h4560));
        serve(1, '0, who);
        chk("t2_who", LW'(who), LW'(1));
        dcache_pmem_write = 1'b0;
        cyc(2);

        // Tie right after reset, then six contended transactions.
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        icache_pmem_address = 16'h2000; icache_pmem_read = 1'b1;
        dcache_pmem_address = 16'h3000; dcache_pmem_read = 1'b1;
        for (int k = 0; k < 6; k++) begin
            serve(1 + k % 2, LW'(k + 16), who);
            order.push_back(who);
        end
        icache_pmem_read = 1'b0;
        dcache_pmem_read = 1'b0;
        for (int k = 0; k < 6; k++)
            chk($sformatf("t3_order%0d", k), LW'(order[k]), LW'(exp_order[k]));
        cyc(2);

        // I arrives while D is in flight.
        dcache_pmem_address = 16'h7770; dcache_pmem_read = 1'b1;
        cyc(1);
        cyc(1);
        icache_pmem_address = 16'h1111; icache_pmem_read = 1'b1;
        cyc(1);
        chk("t4_hold_address", LW'(l2_address), LW'(16'h7770));
        chk("t4_i_resp_quiet", LW'(icache_pmem_resp), '0);
        serve(0, LW'(128'h55), who);
        chk("t4_who_d", LW'(who), LW'(1));
        dcache_pmem_read = 1'b0;
        cyc(1);
        chk("t4_i_turnaround", LW'(l2_read), LW'(1));
        chk("t4_i_address", LW'(l2_address), LW'(16'h1111));
        serve(1, LW'(128'h66), who);
        chk("t4_who_i", LW'(who), LW'(0));
        icache_pmem_read = 1'b0;
        cyc(2);

        // Reset in the middle of a D writeback.
        dcache_pmem_address = 16'h4560; dcache_pmem_write = 1'b1;
        cyc(1);
        chk("t5_l2_write", LW'(l2_write), LW'(1));
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        icache_pmem_read = 1'b1;
        #1;
        chk("t5_write_cleared", LW'(l2_write), '0);
        chk("t5_d_resp_cleared", LW'(dcache_pmem_resp), '0);
        serve(1, '0, who);
        chk("t5_tie_i", LW'(who), LW'(0));
        icache_pmem_read = 1'b0;
        serve(1, '0, who);
        chk("t5_then_d", LW'(who), LW'(1));
        dcache_pmem_write = 1'b0;
        cyc(2);

        // Stray L2 response while idle.
        l2_rdata = LW'(128'h77);
        l2_resp = 1'b1;
        #1;
        chk("t6_i_resp", LW'(icache_pmem_resp), '0);
        chk("t6_d_resp", LW'(dcache_pmem_resp), '0);
        cyc(1);
        chk("t6_i_resp2", LW'(icache_pmem_resp), '0);
        l2_resp = 1'b0;
        cyc(1);
        chk("t6_idle_read", LW'(l2_read), '0);
        chk("t6_idle_write", LW'(l2_write), '0);
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
